// File: rtl/alu_issue_seq_if.sv
// Instruction and result handshake bundle for the ALU issue/writeback stage.
// The master side produces instructions and consumes STORE results; the
// slave side is the issue stage itself.
interface alu_issue_seq_if #(
   parameter int DW = 16
);
   logic          instr_valid;
   logic          instr_ready;
   logic [15:0]   instr;
   logic [DW-1:0] imm;
   logic          res_valid;
   logic          res_ready;
   logic [DW-1:0] res_data;

   modport master (
      output instr_valid,
      input  instr_ready,
      output instr,
      output imm,
      input  res_valid,
      output res_ready,
      input  res_data
   );

   modport slave (
      input  instr_valid,
      output instr_ready,
      input  instr,
      input  imm,
      output res_valid,
      input  res_ready,
      output res_data
   );
endinterface

// File: rtl/alu_issue_seq.sv
// Issue/writeback stage sitting directly in front of the 16-bit combinational
// ALU. It holds a four-entry register file, launches registered operands into
// the ALU, writes the result back one cycle later and returns register values
// to a consumer through the STORE result handshake.
module alu_issue_seq #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   alu_issue_seq_if.slave bus,
   output logic [DW-1:0] alu_m,
   output logic [DW-1:0] alu_n,
   output logic          alu_c,
   output logic [2:0]    alu_opc,
   input  logic [DW-1:0] alu_f,
   input  logic          alu_zer,
   input  logic          alu_neg,
   output logic          flag_z,
   output logic          flag_n,
   output logic          err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      OUT  = 2'd2
   } state_t;

   localparam logic [1:0] KIND_ALU   = 2'b00;
   localparam logic [1:0] KIND_LDI   = 2'b01;
   localparam logic [1:0] KIND_STORE = 2'b10;

   state_t        state;
   logic [DW-1:0] regs [4];
   logic [1:0]    dst_q;
   logic          res_valid_q;
   logic [DW-1:0] res_data_q;

   logic [1:0]    kind;
   logic [2:0]    opc;
   logic          cin;
   logic [1:0]    dst;
   logic [1:0]    srcm;
   logic [1:0]    srcn;
   logic          accept;
   logic          unused_bits;

   // Instruction field decode; the low nibble of the word carries no meaning.
   assign kind        = bus.instr[15:14];
   assign opc         = bus.instr[13:11];
   assign cin         = bus.instr[10];
   assign dst         = bus.instr[9:8];
   assign srcm        = bus.instr[7:6];
   assign srcn        = bus.instr[5:4];
   assign unused_bits = ^bus.instr[3:0];

   // Ready is a pure function of the registered state, so it only rises in IDLE.
   assign bus.instr_ready = (state == IDLE);
   assign accept          = bus.instr_valid && (state == IDLE);
   assign bus.res_valid   = res_valid_q;
   assign bus.res_data    = res_data_q;

   // Control FSM plus all datapath registers; reset abandons any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         for (int i = 0; i < 4; i++) regs[i] <= '0;
         dst_q       <= '0;
         alu_m       <= '0;
         alu_n       <= '0;
         alu_c       <= 1'b0;
         alu_opc     <= '0;
         flag_z      <= 1'b0;
         flag_n      <= 1'b0;
         err         <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  case (kind)
                     KIND_ALU: begin
                        if (opc == 3'b111) begin
                           err <= 1'b1;
                        end else begin
                           alu_m   <= regs[srcm];
                           alu_n   <= regs[srcn];
                           alu_c   <= cin;
                           alu_opc <= opc;
                           dst_q   <= dst;
                           state   <= EXEC;
                        end
                     end
                     KIND_LDI: begin
                        regs[dst] <= bus.imm;
                     end
                     KIND_STORE: begin
                        res_data_q  <= regs[srcm];
                        res_valid_q <= 1'b1;
                        state       <= OUT;
                     end
                     default: begin
                     end
                  endcase
               end
            end
            EXEC: begin
               regs[dst_q] <= alu_f;
               flag_z      <= alu_zer;
               flag_n      <= alu_neg;
               state       <= IDLE;
            end
            OUT: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Sequential issue/writeback stage directly upstream of the team's 16-bit combinational ALU (operands M/N, carry-in C, 3-bit opcode; result F; zero and negative flags).
- Accepts instruction words over a valid/ready handshake and holds a 4-entry register file.
- Drives registered ALU operands, captures the ALU result and flags, and returns register contents on a result handshake.

Parameters:
- DW, 16, data width of the register file, ALU operands and result; instruction format stays fixed at 16 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction word is present.
- instr_ready  out  1  block can accept an instruction.
- instr  in  16  [15:14] kind (00 ALU, 01 LDI, 10 STORE, 11 NOP); [13:11] opc; [10] cin; [9:8] dst; [7:6] srcM; [5:4] srcN.
- imm  in  DW  immediate for LDI; sampled with the instruction.
- alu_m  out  DW  ALU operand M.
- alu_n  out  DW  ALU operand N.
- alu_c  out  1  ALU carry-in.
- alu_opc  out  3  ALU opcode.
- alu_f  in  DW  ALU result.
- alu_zer  in  1  ALU zero flag.
- alu_neg  in  1  ALU negative flag.
- res_valid  out  1  res_data holds a STORE value.
- res_ready  in  1  consumer accepts res_data.
- res_data  out  DW  register value from a STORE.
- flag_z  out  1  registered zero flag of the last committed ALU op.
- flag_n  out  1  registered negative flag of the last committed ALU op.
- err  out  1  sticky illegal-opcode flag.

Behaviour:
- Reset (async, rst=1):
  - Clears R0..R3, alu_m, alu_n, alu_c, alu_opc, res_data, flag_z, flag_n and err to 0.
  - Sets res_valid=0 and state=IDLE; instr_ready=1 once rst deasserts.
  - Reset mid-operation abandons the operation: no writeback, no flag update, any pending STORE is dropped.
- States: IDLE, EXEC, OUT. instr_ready=1 only in IDLE; a transfer happens when instr_valid & instr_ready on a rising edge.
- IDLE, accepted ALU (kind 00) with opc != 3'b111:
  - Latch alu_m=R[srcM], alu_n=R[srcN], alu_c=cin, alu_opc=opc; remember dst; go to EXEC.
- EXEC (exactly one cycle):
  - ALU outputs are combinational from the registered operands.
  - At the EXEC edge: R[dst]<=alu_f, flag_z<=alu_zer, flag_n<=alu_neg; go to IDLE.
  - Throughput is one ALU instruction per 2 cycles; a result is readable from the register file by the next instruction accepted.
- IDLE, accepted ALU with opc=3'b111 (undefined ALU result):
  - Set err=1; no writeback; flags and alu_* unchanged; stay in IDLE.
  - err clears only on reset.
- IDLE, accepted LDI: R[dst]<=imm at the accept edge; flags unchanged; stay in IDLE. Back-to-back LDIs are accepted every cycle.
- IDLE, accepted NOP: no state change.
- IDLE, accepted STORE:
  - res_data<=R[srcM] and res_valid<=1 at the accept edge; go to OUT.
- OUT:
  - res_data and res_valid are held stable while res_ready=0.
  - On res_ready=1 at an edge: res_valid<=0, go to IDLE. Minimum STORE occupancy is 2 cycles.
  - res_ready=1 during IDLE/EXEC is ignored.
- alu_m, alu_n, alu_c and alu_opc change only on acceptance of a legal ALU instruction; they hold their values otherwise.
- dst equal to srcM/srcN is legal: operands are read at accept, and the write happens at the EXEC edge.
- Arithmetic wraps at DW bits; this block performs no arithmetic itself.
- instr changing while instr_ready=0 has no effect.

Test Plan:
- LDI R1=0x0005, LDI R2=0xFFFD, then ALU opc=000 cin=1 dst=R3 srcM=R1 srcN=R2, with the ALU connected:
  - alu_m=0x0005, alu_n=0xFFFD during EXEC.
  - R3=0x0003, flag_z=0, flag_n=0.
  - STORE R3 gives res_data=0x0003.
- ALU opc=010 dst=R0 with srcM=srcN=R1=0x0005 (M+~N+1):
  - R0=0x0000, flag_z=1, flag_n=0.
  - instr_ready low for exactly one cycle after acceptance.
- ALU opc=111:
  - err=1, no register or flag change.
  - instr_ready stays 1.
  - A subsequent legal op still executes.
- STORE with res_ready=0 for 5 cycles, then 1:
  - res_valid=1 and res_data stable for all 6 cycles.
  - instr_ready=0 throughout.
  - Returns to IDLE one cycle after the handshake.
- Assert rst during EXEC of an op targeting R2 (R2 previously 0x1234):
  - R2=0x0000, flags=0, state IDLE, no stale writeback after release.
- Four back-to-back LDIs with instr_valid held high:
  - Each accepted on consecutive cycles.
  - R0..R3 equal the supplied imm values; flags unchanged.
